// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop/lap/clear FSM around the decade counter,
// counting each rising carry edge as one second into BCD MM:SS.
module stopwatch_ctrl #(
  parameter bit WRAP       = 1'b0,
  parameter int MIN_HI_MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       lap_i,
  input  logic       clear_i,
  input  logic       tick_i,
  output logic       en_o,
  output logic [3:0] sec_lo_o,
  output logic [2:0] sec_hi_o,
  output logic [3:0] min_lo_o,
  output logic [3:0] min_hi_o,
  output logic       running_o,
  output logic       ovf_o
);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, LAP, DONE} state_t;

  localparam logic [14:0] TERM = {4'(MIN_HI_MAX), 4'd9, 3'd5, 4'd9};

  state_t      state, state_nxt;
  logic [14:0] digits, digits_nxt, disp;
  logic        tick_q, tick_edge, counting, at_term, ovf_nxt;

  // Digit layout is {min_hi, min_lo, sec_hi, sec_lo}
  function automatic logic [14:0] bcd_inc(input logic [14:0] d);
    logic [3:0] sl, ml, mh;
    logic [2:0] sh;
    {mh, ml, sh, sl} = d;
    if (sl == 4'd9) begin
      sl = 4'd0;
      if (sh == 3'd5) begin
        sh = 3'd0;
        if (ml == 4'd9) begin
          ml = 4'd0;
          mh = mh + 4'd1;
        end else begin
          ml = ml + 4'd1;
        end
      end else begin
        sh = sh + 3'd1;
      end
    end else begin
      sl = sl + 4'd1;
    end
    return {mh, ml, sh, sl};
  endfunction

  always_comb begin
    tick_edge  = tick_i & ~tick_q;
    counting   = tick_edge & ((state == RUN) | (state == LAP));
    at_term    = (digits == TERM);
    state_nxt  = state;
    digits_nxt = digits;
    ovf_nxt    = WRAP ? 1'b0 : ovf_o;

    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (stop_i) state_nxt = PAUSE;
               else if (lap_i) state_nxt = LAP;
      LAP:     if (stop_i) state_nxt = PAUSE;
               else if (lap_i) state_nxt = RUN;
      PAUSE:   if (start_i) state_nxt = RUN;
      default: state_nxt = state;
    endcase

    // A tick coinciding with stop is still counted; overflow beats stop/lap
    if (counting) begin
      if (at_term) begin
        ovf_nxt = 1'b1;
        if (WRAP) digits_nxt = '0;
        else      state_nxt  = DONE;
      end else begin
        digits_nxt = bcd_inc(digits);
      end
    end

    if (clear_i) begin
      state_nxt  = IDLE;
      digits_nxt = '0;
      ovf_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tick_q <= 1'b0;
      digits <= '0;
      disp   <= '0;
      ovf_o  <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick_q <= tick_i;
      digits <= digits_nxt;
      ovf_o  <= ovf_nxt;
      // Display stays frozen at the lap snapshot while in LAP
      if (state_nxt != LAP) disp <= digits_nxt;
    end
  end

  assign en_o      = (state == RUN) | (state == LAP);
  assign running_o = en_o;
  assign {min_hi_o, min_lo_o, sec_hi_o, sec_lo_o} = disp;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a saturating (WRAP=0) and a wrapping
// (WRAP=1) instance driven by the same control and tick stimulus.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0, stop_i = 1'b0, lap_i = 1'b0, clear_i = 1'b0, tick_i = 1'b0;

  logic       en0, run0, ovf0, en1, run1, ovf1;
  logic [3:0] sl0, ml0, mh0, sl1, ml1, mh1;
  logic [2:0] sh0, sh1;
  logic [14:0] d0, d1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.WRAP(1'b0), .MIN_HI_MAX(9)) dut0 (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .lap_i(lap_i),
    .clear_i(clear_i), .tick_i(tick_i), .en_o(en0), .sec_lo_o(sl0),
    .sec_hi_o(sh0), .min_lo_o(ml0), .min_hi_o(mh0), .running_o(run0), .ovf_o(ovf0));

  stopwatch_ctrl #(.WRAP(1'b1), .MIN_HI_MAX(9)) dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .lap_i(lap_i),
    .clear_i(clear_i), .tick_i(tick_i), .en_o(en1), .sec_lo_o(sl1),
    .sec_hi_o(sh1), .min_lo_o(ml1), .min_hi_o(mh1), .running_o(run1), .ovf_o(ovf1));

  assign d0 = {mh0, ml0, sh0, sl0};
  assign d1 = {mh1, ml1, sh1, sl1};

  function automatic logic [14:0] mmss(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  // Each helper starts and ends 1 time unit after a rising edge.
  task automatic do_tick();
    @(posedge clk); #1 tick_i = 1'b1;
    @(posedge clk); #1 tick_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop_i = 1'b1;
    @(posedge clk); #1 stop_i = 1'b0;
  endtask

  task automatic pulse_lap();
    @(posedge clk); #1 lap_i = 1'b1;
    @(posedge clk); #1 lap_i = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({en0, run0, ovf0, d0} !== 18'd0) begin
      n_bad++; $display("FAIL reset_dut0 got=%h want=0", {en0, run0, ovf0, d0});
    end
    n_cmp++;
    if ({en1, run1, ovf1, d1} !== 18'd0) begin
      n_bad++; $display("FAIL reset_dut1 got=%h want=0", {en1, run1, ovf1, d1});
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_start_count();
    @(posedge clk); #1 start_i = 1'b1;
    n_cmp++;
    if (en0 !== 1'b0) begin
      n_bad++; $display("FAIL en_before_start got=%b want=0", en0);
    end
    @(posedge clk); #1 start_i = 1'b0;
    n_cmp++;
    if (en0 !== 1'b1 || run0 !== 1'b1) begin
      n_bad++; $display("FAIL en_after_start got=%b%b want=11", en0, run0);
    end
    ticks(10);
    n_cmp++;
    if (d0 !== mmss(0, 10)) begin
      n_bad++; $display("FAIL count_10 got=%h want=%h", d0, mmss(0, 10));
    end
  endtask

  task automatic test_carry();
    ticks(49);
    n_cmp++;
    if (d0 !== mmss(0, 59)) begin
      n_bad++; $display("FAIL at_0059 got=%h want=%h", d0, mmss(0, 59));
    end
    do_tick();
    n_cmp++;
    if (d0 !== mmss(1, 0)) begin
      n_bad++; $display("FAIL carry_0100 got=%h want=%h", d0, mmss(1, 0));
    end
    ticks(539);
    n_cmp++;
    if (d0 !== mmss(9, 59)) begin
      n_bad++; $display("FAIL at_0959 got=%h want=%h", d0, mmss(9, 59));
    end
    do_tick();
    n_cmp++;
    if (d0 !== mmss(10, 0)) begin
      n_bad++; $display("FAIL carry_1000 got=%h want=%h", d0, mmss(10, 0));
    end
  endtask

  task automatic test_lap();
    pulse_clear();
    n_cmp++;
    if (d0 !== 15'd0 || run0 !== 1'b0) begin
      n_bad++; $display("FAIL clear_idle got=%h run=%b want=0 run=0", d0, run0);
    end
    pulse_start();
    ticks(5);
    pulse_lap();
    ticks(3);
    n_cmp++;
    if (d0 !== mmss(0, 5) || run0 !== 1'b1) begin
      n_bad++; $display("FAIL lap_frozen got=%h run=%b want=%h run=1", d0, run0, mmss(0, 5));
    end
    pulse_lap();
    n_cmp++;
    if (d0 !== mmss(0, 8)) begin
      n_bad++; $display("FAIL lap_release got=%h want=%h", d0, mmss(0, 8));
    end
  endtask

  task automatic test_pause_hold();
    pulse_stop();
    @(posedge clk); #1 tick_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (d0 !== mmss(0, 8) || en0 !== 1'b0) begin
      n_bad++; $display("FAIL pause_hold got=%h en=%b want=%h en=0", d0, en0, mmss(0, 8));
    end
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (d0 !== mmss(0, 8) || en0 !== 1'b1) begin
      n_bad++; $display("FAIL resume_no_recount got=%h en=%b want=%h en=1", d0, en0, mmss(0, 8));
    end
    tick_i = 1'b0;
  endtask

  task automatic test_overflow();
    pulse_clear();
    pulse_start();
    ticks(5999);
    n_cmp++;
    if (d0 !== mmss(99, 59) || d1 !== mmss(99, 59) || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      n_bad++; $display("FAIL at_9959 got=%h/%h ovf=%b%b want=%h ovf=00", d0, d1, ovf0, ovf1, mmss(99, 59));
    end
    do_tick();
    n_cmp++;
    if (d0 !== mmss(99, 59) || ovf0 !== 1'b1 || run0 !== 1'b0) begin
      n_bad++; $display("FAIL sat_done got=%h ovf=%b run=%b want=%h ovf=1 run=0", d0, ovf0, run0, mmss(99, 59));
    end
    n_cmp++;
    if (d1 !== 15'd0 || ovf1 !== 1'b1 || run1 !== 1'b1) begin
      n_bad++; $display("FAIL wrap_zero got=%h ovf=%b run=%b want=0 ovf=1 run=1", d1, ovf1, run1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ovf1 !== 1'b0 || ovf0 !== 1'b1) begin
      n_bad++; $display("FAIL ovf_pulse_vs_sticky got=%b%b want=10", ovf0, ovf1);
    end
    pulse_start();
    do_tick();
    n_cmp++;
    if (run0 !== 1'b0 || d0 !== mmss(99, 59)) begin
      n_bad++; $display("FAIL done_ignores got run=%b d=%h want run=0 d=%h", run0, d0, mmss(99, 59));
    end
    pulse_clear();
    n_cmp++;
    if (d0 !== 15'd0 || ovf0 !== 1'b0 || run0 !== 1'b0) begin
      n_bad++; $display("FAIL clear_from_done got=%h ovf=%b run=%b want=0", d0, ovf0, run0);
    end
  endtask

  task automatic test_clear_with_tick();
    pulse_start();
    ticks(3);
    n_cmp++;
    if (d1 !== mmss(0, 3)) begin
      n_bad++; $display("FAIL pre_clear got=%h want=%h", d1, mmss(0, 3));
    end
    @(posedge clk); #1 clear_i = 1'b1; tick_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0; tick_i = 1'b0;
    n_cmp++;
    if (d1 !== 15'd0 || run1 !== 1'b0 || ovf1 !== 1'b0) begin
      n_bad++; $display("FAIL clear_tick_same got=%h run=%b want=0 run=0", d1, run1);
    end
    do_tick();
    n_cmp++;
    if (d1 !== 15'd0) begin
      n_bad++; $display("FAIL idle_drops_tick got=%h want=0", d1);
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_carry();
    test_lap();
    test_pause_hold();
    test_overflow();
    test_clear_with_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
